// File: rtl/itcm_load_ctrl.sv
// ITCM image loader: packs a byte stream little-endian into 64-bit words and arbitrates the SRAM port.
// Define ITCM_LOAD_CSUM_EN to enable the running byte checksum on load_csum (otherwise tied to 0).
//
// state | meaning
// BOOT  | out of reset, core held, waiting for the first load
// IDLE  | CPU owns the SRAM port, core released
// FILL  | accepting bytes into the pack register
// WRITE | single-cycle SRAM write of the packed word
module itcm_load_ctrl #(
  parameter int AW            = 16,
  parameter int DW            = 64,
  parameter int MW            = 8,
  parameter int LEN_W         = 20,
  parameter int HOLD_AT_RESET = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_start,
  input  logic [AW-1:0]    load_base,
  input  logic [LEN_W-1:0] load_len,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  output logic             in_ready,
  output logic             load_busy,
  output logic             load_done,
  output logic             cpu_hold,
  input  logic             cpu_cs,
  input  logic             cpu_we,
  input  logic [MW-1:0]    cpu_wem,
  input  logic [AW-1:0]    cpu_addr,
  input  logic [DW-1:0]    cpu_din,
  output logic [DW-1:0]    cpu_dout,
  output logic             cpu_busy,
  output logic             ram_cs,
  output logic             ram_we,
  output logic [MW-1:0]    ram_wem,
  output logic [AW-1:0]    ram_addr,
  output logic [DW-1:0]    ram_din,
  input  logic [DW-1:0]    ram_dout,
  output logic [31:0]      load_csum
);

  typedef enum logic [1:0] {BOOT, IDLE, FILL, WRITE} state_t;
  localparam state_t RST_STATE = (HOLD_AT_RESET != 0) ? BOOT : IDLE;

  state_t           state_q, state_d;
  logic [AW-1:0]    base_q, word_idx_q;
  logic [LEN_W-1:0] len_q, byte_cnt_q, byte_cnt_inc;
  logic [DW-1:0]    pack_q;
  logic [MW-1:0]    mask_q;
  logic             in_ready_q, load_done_q;
  logic             accept, start_ok, last_byte, word_full, all_done;

  assign accept       = in_valid & in_ready_q;
  assign start_ok     = load_start & ((state_q == BOOT) | (state_q == IDLE));
  assign byte_cnt_inc = byte_cnt_q + 1'b1;
  assign last_byte    = (byte_cnt_inc == len_q);
  assign word_full    = (byte_cnt_q[2:0] == 3'd7);
  // byte_cnt has already advanced past the last byte by the time WRITE runs
  assign all_done     = (byte_cnt_q == len_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= RST_STATE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    load_busy = 1'b0;
    cpu_hold  = 1'b1;
    cpu_busy  = 1'b1;
    ram_cs    = 1'b0;
    ram_we    = 1'b0;
    ram_wem   = mask_q;
    ram_addr  = base_q + word_idx_q;
    ram_din   = pack_q;
    case (state_q)
      BOOT, IDLE: begin
        if (load_start) state_d = (load_len == '0) ? IDLE : FILL;
      end
      FILL: begin
        load_busy = 1'b1;
        if (accept && (word_full || last_byte)) state_d = WRITE;
      end
      WRITE: begin
        load_busy = 1'b1;
        ram_cs    = 1'b1;
        ram_we    = 1'b1;
        state_d   = all_done ? IDLE : FILL;
      end
      default: state_d = RST_STATE;
    endcase
    if (state_q == IDLE) begin
      cpu_hold = 1'b0;
      cpu_busy = 1'b0;
      ram_cs   = cpu_cs;
      ram_we   = cpu_we;
      ram_wem  = cpu_wem;
      ram_addr = cpu_addr;
      ram_din  = cpu_din;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base_q      <= '0;
      len_q       <= '0;
      byte_cnt_q  <= '0;
      word_idx_q  <= '0;
      pack_q      <= '0;
      mask_q      <= '0;
      in_ready_q  <= 1'b0;
      load_done_q <= 1'b0;
    end else begin
      in_ready_q  <= (state_d == FILL);
      load_done_q <= 1'b0;
      if (start_ok) begin
        base_q      <= load_base;
        len_q       <= load_len;
        byte_cnt_q  <= '0;
        word_idx_q  <= '0;
        pack_q      <= '0;
        mask_q      <= '0;
        load_done_q <= (load_len == '0);
      end else if (state_q == FILL && accept) begin
        pack_q[{byte_cnt_q[2:0], 3'b000} +: 8] <= in_data;
        mask_q[byte_cnt_q[2:0]]               <= 1'b1;
        byte_cnt_q                            <= byte_cnt_inc;
      end else if (state_q == WRITE) begin
        word_idx_q <= word_idx_q + 1'b1;
        pack_q     <= '0;
        mask_q     <= '0;
        if (all_done) load_done_q <= 1'b1;
      end
    end
  end

`ifdef ITCM_LOAD_CSUM_EN
  logic [31:0] csum_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                        csum_q <= '0;
    else if (start_ok)                 csum_q <= '0;
    else if (state_q == FILL && accept) csum_q <= csum_q + {24'd0, in_data};
  end

  assign load_csum = csum_q;
`else
  assign load_csum = 32'd0;
`endif

  assign in_ready  = in_ready_q;
  assign load_done = load_done_q;
  assign cpu_dout  = ram_dout;

endmodule

// File: tb/tb_itcm_load_ctrl.sv
// Scoreboard bench for itcm_load_ctrl: random byte loads checked against a word-packing model.
module tb_itcm_load_ctrl;
  localparam int AW = 16, DW = 64, MW = 8, LEN_W = 20;

  logic clk, rst_n;
  logic load_start;
  logic [AW-1:0] load_base;
  logic [LEN_W-1:0] load_len;
  logic in_valid, in_ready;
  logic [7:0] in_data;
  logic load_busy, load_done, cpu_hold;
  logic cpu_cs, cpu_we;
  logic [MW-1:0] cpu_wem;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_din, cpu_dout;
  logic cpu_busy;
  logic ram_cs, ram_we;
  logic [MW-1:0] ram_wem;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din, ram_dout;
  logic [31:0] load_csum;

  itcm_load_ctrl #(.AW(AW), .DW(DW), .MW(MW), .LEN_W(LEN_W), .HOLD_AT_RESET(1)) dut (
    .clk(clk), .rst_n(rst_n), .load_start(load_start), .load_base(load_base),
    .load_len(load_len), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .load_busy(load_busy), .load_done(load_done), .cpu_hold(cpu_hold),
    .cpu_cs(cpu_cs), .cpu_we(cpu_we), .cpu_wem(cpu_wem), .cpu_addr(cpu_addr),
    .cpu_din(cpu_din), .cpu_dout(cpu_dout), .cpu_busy(cpu_busy),
    .ram_cs(ram_cs), .ram_we(ram_we), .ram_wem(ram_wem), .ram_addr(ram_addr),
    .ram_din(ram_din), .ram_dout(ram_dout), .load_csum(load_csum)
  );

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] din;
    logic [MW-1:0] wem;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  logic [7:0] stim_bytes[0:1023];
  int n_checks = 0, n_fail = 0;
  int done_seen = 0, exp_done = 0;
  logic prev_done = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: word w holds bytes 8w..8w+7, lane b = byte 8w+b, address wraps at 2^AW
  task automatic push_expected(input logic [AW-1:0] base, input int len);
    exp_t e;
    for (int w = 0; w * 8 < len; w++) begin
      e.addr = base + AW'(w);
      e.din  = '0;
      e.wem  = '0;
      for (int b = 0; b < 8; b++) begin
        if (w * 8 + b < len) begin
          e.din[b*8 +: 8] = stim_bytes[w*8+b];
          e.wem[b]        = 1'b1;
        end
      end
      exp_q.push_back(e);
    end
  endtask

  function automatic logic [31:0] model_csum(input int len);
    logic [31:0] s = 32'd0;
    for (int i = 0; i < len; i++) s = s + {24'd0, stim_bytes[i]};
`ifdef ITCM_LOAD_CSUM_EN
    return s;
`else
    return 32'd0;
`endif
  endfunction

  always @(negedge clk) begin
    if (rst_n && ram_cs && ram_we && cpu_busy) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_write: addr %h din %h wem %h", ram_addr, ram_din, ram_wem);
      end else begin
        mon_e = exp_q.pop_front();
        chk("wr_addr", 64'(ram_addr), 64'(mon_e.addr));
        chk("wr_din", ram_din, mon_e.din);
        chk("wr_wem", 64'(ram_wem), 64'(mon_e.wem));
        chk("wr_busy", 64'(load_busy), 64'd1);
      end
    end
    if (load_done) begin
      done_seen++;
      chk("done_width", 64'(prev_done), 64'd0);
    end
    prev_done = load_done;
  end

  task automatic run_load(input logic [AW-1:0] base, input int len, input int gap_pct,
                          input int inject_at);
    int d0, idx, guard;
    logic rdy;
    push_expected(base, len);
    exp_done++;
    d0 = done_seen;
    @(negedge clk);
    load_start = 1'b1;
    load_base  = base;
    load_len   = LEN_W'(len);
    @(negedge clk);
    load_start = 1'b0;
    load_base  = AW'($urandom);
    load_len   = LEN_W'($urandom);
    idx = 0;
    guard = 0;
    while (idx < len && guard < 20000) begin
      rdy = in_ready;
      in_valid = ($urandom_range(99) >= gap_pct);
      in_data  = stim_bytes[idx];
      if (idx == inject_at) begin
        load_start = 1'b1;
        load_base  = 16'h3333;
        load_len   = LEN_W'(2);
      end else begin
        load_start = 1'b0;
      end
      if (rdy && in_valid) idx++;
      @(negedge clk);
      guard++;
    end
    in_valid   = 1'b0;
    load_start = 1'b0;
    if (guard >= 20000) chk("feed_timeout", 64'(idx), 64'(len));
    guard = 0;
    while (done_seen == d0 && guard < 60) begin
      @(negedge clk);
      guard++;
    end
    chk("done_seen", 64'(done_seen), 64'(d0 + 1));
    chk("hold_after_done", 64'(cpu_hold), 64'd0);
    chk("busy_after_done", 64'(load_busy), 64'd0);
    chk("writes_drained", 64'(exp_q.size()), 64'd0);
    chk("csum", 64'(load_csum), 64'(model_csum(len)));
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: sim time %0t limit 2000000", $time);
    $fatal(1, "timeout");
  end

  initial begin
    int len;
    rst_n = 1'b0; load_start = 1'b0; load_base = '0; load_len = '0;
    in_valid = 1'b0; in_data = '0;
    cpu_cs = 1'b1; cpu_we = 1'b0; cpu_wem = '0; cpu_addr = 16'h0001; cpu_din = '0;
    ram_dout = 64'h0123_4567_89AB_CDEF;

    #12;
    chk("rst_hold", 64'(cpu_hold), 64'd1);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_ram_cs", 64'(ram_cs), 64'd0);
    chk("rst_cpu_busy", 64'(cpu_busy), 64'd1);
    chk("rst_done", 64'(load_done), 64'd0);
    chk("rst_csum", 64'(load_csum), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("boot_ram_cs", 64'(ram_cs), 64'd0);
    chk("boot_hold", 64'(cpu_hold), 64'd1);
    cpu_cs = 1'b0;

    for (int i = 0; i < 16; i++) stim_bytes[i] = 8'(i);
    run_load(16'h0000, 16, 0, -1);

    stim_bytes[0] = 8'hAA; stim_bytes[1] = 8'hBB; stim_bytes[2] = 8'hCC;
    run_load(16'h0005, 3, 50, -1);

    @(negedge clk);
    load_start = 1'b1; load_base = 16'h0077; load_len = '0;
    @(negedge clk);
    load_start = 1'b0;
    exp_done++;
    chk("len0_done", 64'(load_done), 64'd1);
    chk("len0_ram_cs", 64'(ram_cs), 64'd0);
    chk("len0_hold", 64'(cpu_hold), 64'd0);
    @(negedge clk);
    chk("len0_done_drop", 64'(load_done), 64'd0);

    cpu_cs = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0001; ram_dout = 64'hDEAD_BEEF_0BAD_F00D;
    #1;
    chk("cpu_rd_cs", 64'(ram_cs), 64'd1);
    chk("cpu_rd_addr", 64'(ram_addr), 64'h1);
    chk("cpu_rd_we", 64'(ram_we), 64'd0);
    chk("cpu_rd_dout", cpu_dout, 64'hDEAD_BEEF_0BAD_F00D);
    chk("cpu_rd_busy", 64'(cpu_busy), 64'd0);
    @(negedge clk);
    cpu_we = 1'b1; cpu_wem = 8'hA5; cpu_addr = 16'h1234; cpu_din = 64'h1122_3344_5566_7788;
    #1;
    chk("cpu_wr_we", 64'(ram_we), 64'd1);
    chk("cpu_wr_wem", 64'(ram_wem), 64'hA5);
    chk("cpu_wr_din", ram_din, 64'h1122_3344_5566_7788);
    @(negedge clk);
    cpu_cs = 1'b0; cpu_we = 1'b0;

    for (int i = 0; i < 10; i++) stim_bytes[i] = 8'($urandom);
    run_load(16'h0100, 10, 20, 4);

    for (int i = 0; i < 16; i++) stim_bytes[i] = 8'($urandom);
    run_load(16'hFFFF, 16, 30, -1);

    for (int k = 0; k < 5; k++) begin
      len = $urandom_range(40, 1);
      for (int i = 0; i < len; i++) stim_bytes[i] = 8'($urandom);
      run_load(AW'($urandom), len, $urandom_range(60), -1);
    end

    @(negedge clk);
    load_start = 1'b1; load_base = 16'h0040; load_len = LEN_W'(20);
    @(negedge clk);
    load_start = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_data = 8'(8'h10 + i);
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk("midfill_busy", 64'(load_busy), 64'd1);
    chk("midfill_hold", 64'(cpu_hold), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 64'(load_busy), 64'd0);
    chk("abort_in_ready", 64'(in_ready), 64'd0);
    chk("abort_hold", 64'(cpu_hold), 64'd1);
    chk("abort_csum", 64'(load_csum), 64'd0);
    chk("abort_ram_cs", 64'(ram_cs), 64'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_abort_hold", 64'(cpu_hold), 64'd1);
    chk("post_abort_in_ready", 64'(in_ready), 64'd0);
    chk("post_abort_cpu_busy", 64'(cpu_busy), 64'd1);

    for (int i = 0; i < 9; i++) stim_bytes[i] = 8'($urandom);
    run_load(16'h0040, 9, 10, -1);

    repeat (3) @(negedge clk);
    chk("final_queue", 64'(exp_q.size()), 64'd0);
    chk("final_done_count", 64'(done_seen), 64'(exp_done));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
